// File: rtl/rggen_rtl_pkg.sv
// ---------------------------------------------------------------------------
// rggen_rtl_pkg
//   Shared types and helpers for the register-access infrastructure.
//   - rggen_status_e        : response status encoding of the access bus
//   - rggen_arbiter_state_e : state encoding of the register-access arbiter
//   - clog2 / index_width   : width helpers for pointers, indices, counters
// ---------------------------------------------------------------------------
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY   = 2'b00,
    RGGEN_EXOKAY = 2'b01,
    RGGEN_SLVERR = 2'b10,
    RGGEN_DECERR = 2'b11
  } rggen_status_e;

  typedef enum logic [1:0] {
    RGGEN_ARB_IDLE     = 2'b00,
    RGGEN_ARB_ACCESS   = 2'b01,
    RGGEN_ARB_RESPONSE = 2'b10
  } rggen_arbiter_state_e;

  // Ceiling of log2; 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Width of an index over 'count' items, never narrower than one bit.
  function automatic int index_width(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

endpackage

// File: rtl/rggen_round_robin_selector.sv
// ---------------------------------------------------------------------------
// rggen_round_robin_selector
//   Purely combinational round-robin pick: the first set request at or above
//   the pointer, searching upward and wrapping to 0.
//   Ports:
//     request_i [N]  : pending requests
//     pointer_i      : highest-priority position for this pick
//     grant_o   [N]  : one-hot grant (all zero when nothing is pending)
//     index_o        : binary index of the granted request
//     found_o        : at least one request was granted
// ---------------------------------------------------------------------------
module rggen_round_robin_selector
  import rggen_rtl_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = index_width(N)
)(
  input  logic [N-1:0]  request_i,
  input  logic [IW-1:0] pointer_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] index_o,
  output logic          found_o
);

  // Walk the requests starting at the pointer and keep only the first hit.
  always_comb begin
    int            sum;
    logic [IW-1:0] candidate;
    grant_o   = {N{1'b0}};
    index_o   = {IW{1'b0}};
    found_o   = 1'b0;
    sum       = 0;
    candidate = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      sum       = int'(pointer_i) + i;
      candidate = IW'((sum >= N) ? (sum - N) : sum);
      if (!found_o && request_i[candidate]) begin
        grant_o[candidate] = 1'b1;
        index_o            = candidate;
        found_o            = 1'b1;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/rggen_register_access_arbiter.sv
// ---------------------------------------------------------------------------
// rggen_register_access_arbiter
//   Shares one register-block access port between REQUESTERS hosts. A request
//   is granted round-robin in IDLE, driven downstream in ACCESS until the
//   downstream completes (or times out), and answered in RESPONSE. Only one
//   access is ever outstanding.
//   Ports:
//     i_clk, i_rst_n       : clock, asynchronous active-low reset
//     i_req_*              : packed per-host request (valid/write/addr/data/mask)
//     o_req_ready          : one-cycle pulse, request consumed
//     o_resp_valid         : one-cycle pulse to the granted host
//     o_resp_status/_read_data : result of the completed access
//     o_access_*           : downstream access, fields held while valid
//     i_access_ready/_status/_read_data : downstream completion
// ---------------------------------------------------------------------------
module rggen_register_access_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int REQUESTERS     = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [REQUESTERS-1:0]               i_req_valid,
  input  logic [REQUESTERS-1:0]               i_req_write,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]    i_req_write_data,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]    i_req_write_mask,
  output logic [REQUESTERS-1:0]               o_req_ready,
  output logic [REQUESTERS-1:0]               o_resp_valid,
  output logic [1:0]                          o_resp_status,
  output logic [DATA_WIDTH-1:0]               o_resp_read_data,
  output logic                                o_access_valid,
  output logic                                o_access_write,
  output logic [ADDRESS_WIDTH-1:0]            o_access_address,
  output logic [DATA_WIDTH-1:0]               o_access_write_data,
  output logic [DATA_WIDTH-1:0]               o_access_write_mask,
  input  logic                                i_access_ready,
  input  logic [1:0]                          i_access_status,
  input  logic [DATA_WIDTH-1:0]               i_access_read_data
);

  localparam int            IW         = index_width(REQUESTERS);
  localparam logic [IW-1:0] LAST_INDEX = IW'(REQUESTERS - 1);

  rggen_arbiter_state_e    state_q, state_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic                    write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
  logic [DATA_WIDTH-1:0]   write_mask_q, write_mask_d;
  rggen_status_e           status_q, status_d;
  logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;

  logic [REQUESTERS-1:0]   select_grant_s;
  logic [IW-1:0]           select_index_s;
  logic                    select_found_s;
  logic                    timeout_s;

  rggen_round_robin_selector #(
    .N (REQUESTERS)
  ) u_selector (
    .request_i (i_req_valid),
    .pointer_i (rr_ptr_q),
    .grant_o   (select_grant_s),
    .index_o   (select_index_s),
    .found_o   (select_found_s)
  );

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int CW = index_width(TIMEOUT_CYCLES);
    logic [CW-1:0] count_q, count_d;

    // Count cycles spent in ACCESS; cleared everywhere else.
    always_comb begin
      if (state_q == RGGEN_ARB_ACCESS) begin
        count_d = count_q + CW'(1);
      end else begin
        count_d = {CW{1'b0}};
      end
    end

    // Timeout counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        count_q <= {CW{1'b0}};
      end else begin
        count_q <= count_d;
      end
    end

    // Fires in the last allowed ACCESS cycle, so access_valid lasts TIMEOUT_CYCLES.
    assign timeout_s = (state_q == RGGEN_ARB_ACCESS) &&
                       (count_q == CW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_timeout
    assign timeout_s = 1'b0;
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RGGEN_ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RGGEN_ARB_IDLE: begin
        if (select_found_s) begin
          state_d = RGGEN_ARB_ACCESS;
        end else begin
          state_d = RGGEN_ARB_IDLE;
        end
      end
      RGGEN_ARB_ACCESS: begin
        if (i_access_ready || timeout_s) begin
          state_d = RGGEN_ARB_RESPONSE;
        end else begin
          state_d = RGGEN_ARB_ACCESS;
        end
      end
      RGGEN_ARB_RESPONSE: state_d = RGGEN_ARB_IDLE;
      default:            state_d = RGGEN_ARB_IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state (ready also from the selector).
  always_comb begin
    o_req_ready    = {REQUESTERS{1'b0}};
    o_resp_valid   = {REQUESTERS{1'b0}};
    o_access_valid = 1'b0;
    case (state_q)
      RGGEN_ARB_IDLE:     o_req_ready           = select_grant_s;
      RGGEN_ARB_ACCESS:   o_access_valid        = 1'b1;
      RGGEN_ARB_RESPONSE: o_resp_valid[grant_q] = 1'b1;
      default:            o_access_valid        = 1'b0;
    endcase
  end

  // Next values of the latched request, response and round-robin pointer.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    write_d      = write_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    write_mask_d = write_mask_q;
    status_d     = status_q;
    read_data_d  = read_data_q;
    case (state_q)
      RGGEN_ARB_IDLE: begin
        if (select_found_s) begin
          grant_d      = select_index_s;
          write_d      = i_req_write[select_index_s];
          address_d    = i_req_address[int'(select_index_s)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          write_data_d = i_req_write_data[int'(select_index_s)*DATA_WIDTH +: DATA_WIDTH];
          write_mask_d = i_req_write_mask[int'(select_index_s)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          grant_d = grant_q;
        end
      end
      RGGEN_ARB_ACCESS: begin
        // A completion in the timeout cycle still reports the real status.
        if (i_access_ready) begin
          status_d    = rggen_status_e'(i_access_status);
          read_data_d = i_access_read_data;
        end else if (timeout_s) begin
          status_d    = RGGEN_SLVERR;
          read_data_d = {DATA_WIDTH{1'b0}};
        end else begin
          status_d = status_q;
        end
      end
      RGGEN_ARB_RESPONSE: begin
        rr_ptr_d = (grant_q == LAST_INDEX) ? {IW{1'b0}} : (grant_q + IW'(1));
      end
      default: rr_ptr_d = rr_ptr_q;
    endcase
  end

  // Latched request, response and pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q     <= {IW{1'b0}};
      grant_q      <= {IW{1'b0}};
      write_q      <= 1'b0;
      address_q    <= {ADDRESS_WIDTH{1'b0}};
      write_data_q <= {DATA_WIDTH{1'b0}};
      write_mask_q <= {DATA_WIDTH{1'b0}};
      status_q     <= RGGEN_OKAY;
      read_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      write_q      <= write_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      write_mask_q <= write_mask_d;
      status_q     <= status_d;
      read_data_q  <= read_data_d;
    end
  end

  assign o_access_write      = write_q;
  assign o_access_address    = address_q;
  assign o_access_write_data = write_data_q;
  assign o_access_write_mask = write_mask_q;
  assign o_resp_status       = status_q;
  assign o_resp_read_data    = read_data_q;

endmodule
